regfile_seq: RTL and testbench
==============================

# regfile_seq

Sequencer that drives the 8-entry, 8-bit register file's control pins (REGWRITE, SETSRC, SETDEST, MOV, rt_index, write_value) from a single valid/ready request port. It turns one three-operand request (dest, src, rt) into the required pointer-load cycles followed by one execute cycle. It sits between instruction decode and the register file, with the ALU in the loop: rs/rt go from the register file to the ALU, and alu_result comes back in.

## Interface
- REG_W, 8, register data width
- IDX_W, 3, register index width
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request (high only in IDLE)
- req_op  input  2  0=WRITE (dest←alu_result), 1=MOV (r7←req_data), 2=READ (load pointers, present operands, no write), 3=reserved
- req_dest / req_src / req_rt  input  IDX_W  register indices
- req_data  input  REG_W  immediate for MOV
- alu_result  input  REG_W  combinational ALU output computed from register file rs/rt
- ptr_inval  input  1  external pointer change; clears cache (REGSEQ_PTR_CACHE_EN only)
- REGWRITE, SETSRC, SETDEST, MOV  output  1 each  register file controls
- rt_index  output  IDX_W  register file index/pointer operand
- write_value  output  REG_W  register file write data
- done  output  1  one-cycle pulse in the EXEC cycle
- op_err  output  1  one-cycle pulse in the EXEC cycle of a reserved op

## Operation
- FSM states: IDLE, SET_SRC, SET_DEST, EXEC.
- In IDLE, when req_valid & req_ready, latch op/dest/src/rt/data.
- Transitions from IDLE:
  - WRITE or READ → SET_SRC.
  - MOV or reserved → EXEC.
- Pointer sequence: SET_SRC → SET_DEST → EXEC → IDLE.
- Outputs are decoded from the registered state and latched fields only. They are not functions of the current req_* inputs.
  - SET_SRC: SETSRC=1, rt_index=src.
  - SET_DEST: SETDEST=1, rt_index=dest.
  - EXEC, WRITE: REGWRITE=1, rt_index=rt, write_value=alu_result.
  - EXEC, MOV: REGWRITE=1, MOV=1, write_value=data.
  - EXEC, READ: rt_index=rt, no control asserted.
  - EXEC, reserved: no control asserted, op_err=1.
- At most one of SETSRC, SETDEST, and REGWRITE is high in any cycle. MOV is high only together with REGWRITE.
- In every other state, all controls are 0, rt_index=0, and write_value=0.
- Once a request is accepted it runs to completion. req_valid is ignored outside IDLE.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, req_ready=1.
  - All other outputs are 0 and latched fields are 0.
  - Pointer cache is invalid.
- Reset mid-operation aborts with no further register file pulses. The register file's pointers are then unknown, so the cache must be invalid.
- Accept at edge k. Uncached latency: WRITE/READ EXEC at cycle k+3; MOV/reserved EXEC at cycle k+1.
- req_ready returns to 1 in the cycle after EXEC. Back-to-back throughput: one request per (latency+1) cycles.
- The register file samples controls on the same edge that leaves the state. The write commits at the edge ending EXEC.
- done coincides with EXEC.

## Configuration
- REGSEQ_PTR_CACHE_EN defined: the sequencer shadows the src and dest pointers, each with its own valid bit.
  - SET_SRC is skipped when src_valid and the cached src equals the request src. SET_DEST is skipped under the same rule.
  - A cached pointer is updated and marked valid on the edge ending its SET state.
  - ptr_inval or reset clears both valid bits. ptr_inval has priority over an update in the same cycle.
  - A fully cached WRITE reaches EXEC at k+1.
- REGSEQ_PTR_CACHE_EN undefined: every WRITE/READ visits both SET states, the ptr_inval port is present but ignored, and there is no cache logic.

## Structure
- Package regseq_pkg:
  - op enum (OP_WRITE, OP_MOV, OP_READ, OP_RSVD).
  - FSM state enum.
  - MOV_DEST_IDX=7.
  - Default REG_W/IDX_W.
- One optional sub-module, regseq_ptr_cache: two index registers plus valid bits, with hit outputs. It is instantiated only under REGSEQ_PTR_CACHE_EN.

## Test plan
- After reset: WRITE dest=2, src=1, rt=3, alu_result=0x5A → SETSRC (rt_index=1) at k+1, SETDEST (rt_index=2) at k+2, REGWRITE at k+3 with write_value=0x5A and done=1; req_ready=1 at k+4.
- MOV data=0xC3 → k+1 has REGWRITE=1, MOV=1, write_value=0xC3, done=1; no SET pulses.
- Cache on: WRITE 2,1,3 then WRITE 2,1,4 → the second request asserts REGWRITE at k+1 with rt_index=4. Pulse ptr_inval, repeat → full 3-cycle sequence.
- READ src=5, rt=6 → SETSRC then SETDEST, EXEC with rt_index=6, REGWRITE=0, done=1. Reserved op → EXEC at k+1 with op_err=1 and no controls.
- RST_N low during SET_DEST → all outputs 0 immediately, req_ready=1 after release, and the next WRITE (cache on) performs both SET cycles.
- req_valid held high with changing fields during a busy request → fields are ignored until IDLE and no extra pulses occur.

Source files
------------

// File: rtl/regseq_pkg.sv
// regseq_pkg: shared types and constants for the register-file sequencer.
//   op_e     request opcode (WRITE / MOV / READ / reserved)
//   state_e  sequencer FSM state
//   MOV_DEST_IDX  register implicitly written by a MOV (the register file wires MOV to r7)
package regseq_pkg;

    localparam int unsigned DEFAULT_REG_W = 8;
    localparam int unsigned DEFAULT_IDX_W = 3;
    localparam int unsigned MOV_DEST_IDX  = 7;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_MOV   = 2'd1,
        OP_READ  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StSetSrc,
        StSetDest,
        StExec
    } state_e;

    // Ops that go through the src/dest pointer-load cycles.
    function automatic logic needs_ptrs(op_e op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/regseq_ptr_cache.sv
// regseq_ptr_cache: shadow copy of the register file's src and dest pointers.
// Ports:
//   CLK, RST_N          clock, async active-low reset (clears both valid bits)
//   ptr_inval           external pointer change; clears both valid bits, wins over updates
//   upd_src / upd_dest  load src_idx / dest_idx into the shadow and mark it valid
//   src_idx / dest_idx  index to compare against (and to load on update)
//   src_hit / dest_hit  shadow is valid, equal to the index, and not being invalidated
module regseq_ptr_cache
    import regseq_pkg::*;
#(
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ptr_inval,
    input  logic             upd_src,
    input  logic             upd_dest,
    input  logic [IDX_W-1:0] src_idx,
    input  logic [IDX_W-1:0] dest_idx,
    output logic             src_hit,
    output logic             dest_hit
);

    logic [IDX_W-1:0] src_q, dest_q;
    logic             src_v_q, dest_v_q;

    // A same-cycle ptr_inval means the real pointer may already differ, so no hit.
    assign src_hit  = src_v_q && (src_q == src_idx) && !ptr_inval;
    assign dest_hit = dest_v_q && (dest_q == dest_idx) && !ptr_inval;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_q    <= '0;
            dest_q   <= '0;
            src_v_q  <= 1'b0;
            dest_v_q <= 1'b0;
        end else if (ptr_inval) begin
            src_v_q  <= 1'b0;
            dest_v_q <= 1'b0;
        end else begin
            if (upd_src) begin
                src_q   <= src_idx;
                src_v_q <= 1'b1;
            end
            if (upd_dest) begin
                dest_q   <= dest_idx;
                dest_v_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: turns one (dest, src, rt) request into register-file pointer-load cycles
// followed by a single execute cycle.
// Optional feature: define REGSEQ_PTR_CACHE_EN to skip pointer loads that would rewrite
// a pointer the register file already holds.
// Ports:
//   CLK, RST_N                    clock, async active-low reset
//   req_valid / req_ready         request handshake (ready only in idle)
//   req_op, req_dest, req_src,
//   req_rt, req_data              request fields, latched on accept
//   alu_result                    ALU output, forwarded as write data in a WRITE execute
//   ptr_inval                     external pointer change (used only with the cache)
//   REGWRITE, SETSRC, SETDEST,
//   MOV, rt_index, write_value    register file controls
//   done, op_err                  execute-cycle pulses (op_err for the reserved op)
module regfile_seq
    import regseq_pkg::*;
#(
    parameter int unsigned REG_W = DEFAULT_REG_W,
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_dest,
    input  logic [IDX_W-1:0] req_src,
    input  logic [IDX_W-1:0] req_rt,
    input  logic [REG_W-1:0] req_data,
    input  logic [REG_W-1:0] alu_result,
    input  logic             ptr_inval,
    output logic             REGWRITE,
    output logic             SETSRC,
    output logic             SETDEST,
    output logic             MOV,
    output logic [IDX_W-1:0] rt_index,
    output logic [REG_W-1:0] write_value,
    output logic             done,
    output logic             op_err
);

    state_e           state_q;
    op_e              op_q;
    logic [IDX_W-1:0] dest_q, src_q, rt_q;
    logic [REG_W-1:0] data_q;
    logic             src_hit, dest_hit;

`ifdef REGSEQ_PTR_CACHE_EN
    logic [IDX_W-1:0] cmp_src, cmp_dest;

    // In idle the hit decision is for the incoming request; afterwards for the latched one.
    assign cmp_src  = (state_q == StIdle) ? req_src : src_q;
    assign cmp_dest = (state_q == StIdle) ? req_dest : dest_q;

    regseq_ptr_cache #(
        .IDX_W (IDX_W)
    ) u_ptr_cache (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ptr_inval(ptr_inval),
        .upd_src  (state_q == StSetSrc),
        .upd_dest (state_q == StSetDest),
        .src_idx  (cmp_src),
        .dest_idx (cmp_dest),
        .src_hit  (src_hit),
        .dest_hit (dest_hit)
    );
`else
    logic unused_ptr_inval;

    assign unused_ptr_inval = ptr_inval;
    assign src_hit          = 1'b0;
    assign dest_hit         = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            op_q    <= OP_WRITE;
            dest_q  <= '0;
            src_q   <= '0;
            rt_q    <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q   <= op_e'(req_op);
                        dest_q <= req_dest;
                        src_q  <= req_src;
                        rt_q   <= req_rt;
                        data_q <= req_data;
                        if (!needs_ptrs(op_e'(req_op))) begin
                            state_q <= StExec;
                        end else if (!src_hit) begin
                            state_q <= StSetSrc;
                        end else if (!dest_hit) begin
                            state_q <= StSetDest;
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StSetSrc:  state_q <= dest_hit ? StExec : StSetDest;
                StSetDest: state_q <= StExec;
                StExec:    state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    // Controls depend only on registered state and latched fields; alu_result passes
    // through in a WRITE execute because the ALU reads the freshly loaded pointers.
    always_comb begin
        req_ready   = 1'b0;
        REGWRITE    = 1'b0;
        SETSRC      = 1'b0;
        SETDEST     = 1'b0;
        MOV         = 1'b0;
        rt_index    = '0;
        write_value = '0;
        done        = 1'b0;
        op_err      = 1'b0;
        unique case (state_q)
            StIdle:    req_ready = 1'b1;
            StSetSrc: begin
                SETSRC   = 1'b1;
                rt_index = src_q;
            end
            StSetDest: begin
                SETDEST  = 1'b1;
                rt_index = dest_q;
            end
            StExec: begin
                done = 1'b1;
                unique case (op_q)
                    OP_WRITE: begin
                        REGWRITE    = 1'b1;
                        rt_index    = rt_q;
                        write_value = alu_result;
                    end
                    OP_MOV: begin
                        REGWRITE    = 1'b1;
                        MOV         = 1'b1;
                        write_value = data_q;
                    end
                    OP_READ:  rt_index = rt_q;
                    default:  op_err = 1'b1;
                endcase
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_regfile_seq.sv
module tb_regfile_seq;
    import regseq_pkg::*;

`ifdef REGSEQ_PTR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [2:0] req_dest = '0, req_src = '0, req_rt = '0;
    logic [7:0] req_data = '0, alu_result = '0;
    logic       ptr_inval = 1'b0;
    logic       REGWRITE, SETSRC, SETDEST, MOV, done, op_err;
    logic [2:0] rt_index;
    logic [7:0] write_value;

    regfile_seq dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_dest   (req_dest),
        .req_src    (req_src),
        .req_rt     (req_rt),
        .req_data   (req_data),
        .alu_result (alu_result),
        .ptr_inval  (ptr_inval),
        .REGWRITE   (REGWRITE),
        .SETSRC     (SETSRC),
        .SETDEST    (SETDEST),
        .MOV        (MOV),
        .rt_index   (rt_index),
        .write_value(write_value),
        .done       (done),
        .op_err     (op_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ready;
        logic       regwrite;
        logic       setsrc;
        logic       setdest;
        logic       mov;
        logic [2:0] rt;
        logic [7:0] wv;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct {
        op_e        op;
        logic [2:0] dest;
        logic [2:0] src;
        logic [2:0] rt;
        logic [7:0] data;
        logic [7:0] alu;
        bit         inval;
        bit         hold;
    } vec_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Model of the pointers held by the register file as seen by the sequencer.
    bit         m_sv = 0, m_dv = 0;
    logic [2:0] m_s = '0, m_d = '0;

    vec_t vecs[10];

    function automatic vec_t mkv(op_e op, logic [2:0] d, logic [2:0] s, logic [2:0] rt,
                                 logic [7:0] data, logic [7:0] alu, bit inval, bit hold);
        vec_t v;
        v.op = op; v.dest = d; v.src = s; v.rt = rt;
        v.data = data; v.alu = alu; v.inval = inval; v.hold = hold;
        return v;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.ready = req_ready; o.regwrite = REGWRITE; o.setsrc = SETSRC; o.setdest = SETDEST;
        o.mov = MOV; o.rt = rt_index; o.wv = write_value; o.done = done; o.err = op_err;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (rdy/rw/ss/sd/mv/rt/wv/done/err) expected %h",
                     name, act, exp);
        end
    endtask

    // Push the expected per-cycle outputs of a request, from the cycle after accept
    // through the idle cycle that follows execute.
    task automatic model_push(input vec_t v);
        obs_t o;
        if (v.op == OP_WRITE || v.op == OP_READ) begin
            if (!(CACHE && m_sv && m_s == v.src)) begin
                o = '0; o.setsrc = 1'b1; o.rt = v.src;
                exp_q.push_back(o);
                m_sv = 1; m_s = v.src;
            end
            if (!(CACHE && m_dv && m_d == v.dest)) begin
                o = '0; o.setdest = 1'b1; o.rt = v.dest;
                exp_q.push_back(o);
                m_dv = 1; m_d = v.dest;
            end
        end
        o = '0;
        o.done = 1'b1;
        case (v.op)
            OP_WRITE: begin o.regwrite = 1'b1; o.rt = v.rt; o.wv = v.alu; end
            OP_MOV:   begin o.regwrite = 1'b1; o.mov = 1'b1; o.wv = v.data; end
            OP_READ:  o.rt = v.rt;
            default:  o.err = 1'b1;
        endcase
        exp_q.push_back(o);
        exp_q.push_back(idle_obs());
    endtask

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1;
        req_op = v.op; req_dest = v.dest; req_src = v.src; req_rt = v.rt;
        req_data = v.data; alu_result = v.alu;
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge, DUT idle.
    task automatic run_req(input vec_t v, input string name);
        if (v.inval) begin
            ptr_inval = 1'b1;
            @(negedge CLK);
            ptr_inval = 1'b0;
            m_sv = 0; m_dv = 0;
        end
        check({name, " idle"}, idle_obs());
        drive_req(v);
        model_push(v);
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            @(negedge CLK);
            check($sformatf("%s c%0d", name, cyc + 1), exp_q.pop_front());
            if (v.hold && exp_q.size() > 0) begin
                // Busy: keep valid high with scrambled fields; must be ignored.
                req_valid = 1'b1;
                req_op = 2'($urandom_range(3));
                req_dest = 3'($urandom); req_src = 3'($urandom); req_rt = 3'($urandom);
                req_data = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = mkv(OP_WRITE, 3'd2, 3'd1, 3'd3, 8'h00, 8'h5A, 0, 0);
        vecs[1] = mkv(OP_MOV,   3'd0, 3'd0, 3'd0, 8'hC3, 8'h11, 0, 0);
        vecs[2] = mkv(OP_WRITE, 3'd2, 3'd1, 3'd4, 8'h00, 8'h3C, 0, 0);
        vecs[3] = mkv(OP_WRITE, 3'd2, 3'd1, 3'd4, 8'h00, 8'h96, 1, 0);
        vecs[4] = mkv(OP_READ,  3'd2, 3'd5, 3'd6, 8'h00, 8'h77, 1, 0);
        vecs[5] = mkv(OP_RSVD,  3'd1, 3'd2, 3'd3, 8'hFF, 8'hEE, 0, 0);
        vecs[6] = mkv(OP_WRITE, 3'd4, 3'd5, 3'd1, 8'h00, 8'hA5, 0, 1);
        vecs[7] = mkv(OP_MOV,   3'd6, 3'd6, 3'd6, 8'h81, 8'h00, 0, 1);
        vecs[8] = mkv(OP_WRITE, 3'd4, 3'd5, 3'd2, 8'h00, 8'h01, 0, 0);
        vecs[9] = mkv(OP_WRITE, 3'd4, 3'd6, 3'd0, 8'h00, 8'hFE, 0, 0);

        // Reset state
        #3;
        check("in reset", idle_obs());
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("after reset", idle_obs());

        foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while in the dest pointer-load cycle.
        begin
            vec_t v;
            obs_t o;
            v = mkv(OP_WRITE, 3'd3, 3'd2, 3'd5, 8'h00, 8'h42, 0, 0);
            ptr_inval = 1'b1;
            @(negedge CLK);
            ptr_inval = 1'b0;
            drive_req(v);
            @(negedge CLK);
            req_valid = 1'b0;
            o = '0; o.setsrc = 1'b1; o.rt = 3'd2;
            check("abort setsrc", o);
            @(negedge CLK);
            o = '0; o.setdest = 1'b1; o.rt = 3'd3;
            check("abort setdest", o);
            #2 RST_N = 1'b0;
            #1 check("abort in reset", idle_obs());
            m_sv = 0; m_dv = 0;
            @(negedge CLK);
            RST_N = 1'b1;
            @(negedge CLK);
            check("abort released", idle_obs());
            run_req(v, "post-abort");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound in case the DUT stalls something unexpectedly.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, required finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
